// File: rtl/serial_compare_ctrl_if.sv
// Request/result bundle between a controller (master) and serial_compare_ctrl (slave).
// Carries the start handshake, both operands and the registered compare result.
interface serial_compare_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             gt;
    logic             eq;
    logic             lt;

    modport master (
        output start, a, b,
        input  busy, done, gt, eq, lt
    );

    modport slave (
        input  start, a, b,
        output busy, done, gt, eq, lt
    );
endinterface

// File: rtl/serial_compare_ctrl.sv
// Wide unsigned magnitude compare built from one 2-bit slice, scanned MSB-first one pair per clock.
// Optional macro SERIAL_COMPARE_EARLY_EXIT_EN ends the scan on the first differing pair.
module serial_compare_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_compare_ctrl_if.slave bus
);
    localparam int N  = WIDTH / 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [CW-1:0]    pairCnt_q, pairCnt_d;
    logic             decided_q, decided_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             lt_q, lt_d;

    logic [1:0]       topA;
    logic [1:0]       topB;
    logic             pairDiffers;
    logic             lastPair;
    logic             finishRun;

    assign topA        = sa_q[WIDTH-1 -: 2];
    assign topB        = sb_q[WIDTH-1 -: 2];
    assign pairDiffers = (topA != topB);
    assign lastPair    = (pairCnt_q == CW'(N - 1));

`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
    assign finishRun   = lastPair || (!decided_q && pairDiffers);
`else
    assign finishRun   = lastPair;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sa_q      <= '0;
            sb_q      <= '0;
            pairCnt_q <= '0;
            decided_q <= 1'b0;
            gt_q      <= 1'b0;
            eq_q      <= 1'b0;
            lt_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            pairCnt_q <= pairCnt_d;
            decided_q <= decided_d;
            gt_q      <= gt_d;
            eq_q      <= eq_d;
            lt_q      <= lt_d;
        end
    end

    // The first differing pair fixes the result; later pairs only shift through.
    always_comb begin
        state_d   = state_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        pairCnt_d = pairCnt_q;
        decided_d = decided_q;
        gt_d      = gt_q;
        eq_d      = eq_q;
        lt_d      = lt_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sa_d      = bus.a;
                    sb_d      = bus.b;
                    pairCnt_d = '0;
                    decided_d = 1'b0;
                    gt_d      = 1'b0;
                    eq_d      = 1'b0;
                    lt_d      = 1'b0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (!decided_q && pairDiffers) begin
                    gt_d      = (topA > topB);
                    lt_d      = (topA < topB);
                    decided_d = 1'b1;
                end
                sa_d      = sa_q << 2;
                sb_d      = sb_q << 2;
                pairCnt_d = pairCnt_q + CW'(1);
                if (finishRun) begin
                    state_d = DONE;
                    if (!decided_q && !pairDiffers) begin
                        eq_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.gt   = gt_q;
    assign bus.eq   = eq_q;
    assign bus.lt   = lt_q;
endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Directed bench for serial_compare_ctrl: an 8-bit and a 2-bit instance sharing clock and reset.
// Expected latencies follow SERIAL_COMPARE_EARLY_EXIT_EN when the bench is built with it.
module tb_serial_compare_ctrl;
    logic clk;
    logic rst;
    int   assertCount;
    int   failCount;

`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    serial_compare_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_compare_ctrl_if #(.WIDTH(2)) bus2 ();

    serial_compare_ctrl #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    serial_compare_ctrl #(.WIDTH(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doCompare8(input logic [7:0] a, input logic [7:0] b,
                              input logic [2:0] expRes, input int expLat,
                              input string name);
        int cycles;
        int busyCycles;
        bus8.a     = a;
        bus8.b     = b;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        bus8.a     = ~a;
        bus8.b     = ~b;
        assertCount++;
        if ({bus8.gt, bus8.eq, bus8.lt} !== 3'b000) begin
            failCount++;
            $display("[TB] FAIL %s_cleared: got %b expected 000", name, {bus8.gt, bus8.eq, bus8.lt});
        end
        cycles     = 0;
        busyCycles = 0;
        while (bus8.done !== 1'b1 && cycles < 20) begin
            if (bus8.busy === 1'b1) busyCycles++;
            tick();
            cycles++;
        end
        if (bus8.busy === 1'b1) busyCycles++;
        assertCount++;
        if (cycles !== expLat) begin
            failCount++;
            $display("[TB] FAIL %s_latency: got %0d expected %0d", name, cycles, expLat);
        end
        assertCount++;
        if (busyCycles !== expLat + 1) begin
            failCount++;
            $display("[TB] FAIL %s_busy_cycles: got %0d expected %0d", name, busyCycles, expLat + 1);
        end
        assertCount++;
        if ({bus8.gt, bus8.eq, bus8.lt} !== expRes) begin
            failCount++;
            $display("[TB] FAIL %s_result: got %b expected %b", name, {bus8.gt, bus8.eq, bus8.lt}, expRes);
        end
        tick();
        assertCount++;
        if ({bus8.busy, bus8.done, bus8.gt, bus8.eq, bus8.lt} !== {2'b00, expRes}) begin
            failCount++;
            $display("[TB] FAIL %s_after_done: got %b expected %b", name,
                     {bus8.busy, bus8.done, bus8.gt, bus8.eq, bus8.lt}, {2'b00, expRes});
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        bus8.start = 1'b0;
        bus8.a     = '0;
        bus8.b     = '0;
        bus2.start = 1'b0;
        bus2.a     = '0;
        bus2.b     = '0;
        tick();
        tick();
        rst = 1'b0;
        assertCount++;
        if ({bus8.busy, bus8.done, bus8.gt, bus8.eq, bus8.lt} !== 5'b00000) begin
            failCount++;
            $display("[TB] FAIL reset8: got %b expected 00000", {bus8.busy, bus8.done, bus8.gt, bus8.eq, bus8.lt});
        end
        assertCount++;
        if ({bus2.busy, bus2.done, bus2.gt, bus2.eq, bus2.lt} !== 5'b00000) begin
            failCount++;
            $display("[TB] FAIL reset2: got %b expected 00000", {bus2.busy, bus2.done, bus2.gt, bus2.eq, bus2.lt});
        end
        tick();
        assertCount++;
        if (bus8.busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL idle_no_start: got busy=%b expected 0", bus8.busy);
        end
    endtask

    task automatic test_equal();
        doCompare8(8'hA5, 8'hA5, 3'b010, 4, "eq_A5");
    endtask

    task automatic test_gt_early();
        doCompare8(8'h80, 8'h7F, 3'b100, EARLY ? 1 : 4, "gt_80_7F");
    endtask

    task automatic test_lt_last_pair();
        doCompare8(8'h12, 8'h13, 3'b001, 4, "lt_12_13");
    endtask

    task automatic test_back_to_back();
        int cycles;
        bus8.a     = 8'h40;
        bus8.b     = 8'h30;
        bus8.start = 1'b1;
        tick();
        bus8.a = 8'h00;
        bus8.b = 8'hFF;
        cycles = 0;
        while (bus8.done !== 1'b1 && cycles < 20) begin
            tick();
            cycles++;
        end
        assertCount++;
        if (cycles !== (EARLY ? 1 : 4) || {bus8.gt, bus8.eq, bus8.lt} !== 3'b100) begin
            failCount++;
            $display("[TB] FAIL b2b_first: got lat=%0d res=%b expected lat=%0d res=100",
                     cycles, {bus8.gt, bus8.eq, bus8.lt}, EARLY ? 1 : 4);
        end
        tick();
        assertCount++;
        if ({bus8.busy, bus8.gt, bus8.eq, bus8.lt} !== 4'b0100) begin
            failCount++;
            $display("[TB] FAIL b2b_idle_gap: got %b expected 0100", {bus8.busy, bus8.gt, bus8.eq, bus8.lt});
        end
        tick();
        bus8.start = 1'b0;
        assertCount++;
        if ({bus8.busy, bus8.gt, bus8.eq, bus8.lt} !== 4'b1000) begin
            failCount++;
            $display("[TB] FAIL b2b_second_accept: got %b expected 1000", {bus8.busy, bus8.gt, bus8.eq, bus8.lt});
        end
        cycles = 0;
        while (bus8.done !== 1'b1 && cycles < 20) begin
            tick();
            cycles++;
        end
        assertCount++;
        if (cycles !== (EARLY ? 1 : 4) || {bus8.gt, bus8.eq, bus8.lt} !== 3'b001) begin
            failCount++;
            $display("[TB] FAIL b2b_second: got lat=%0d res=%b expected lat=%0d res=001",
                     cycles, {bus8.gt, bus8.eq, bus8.lt}, EARLY ? 1 : 4);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        bus8.a     = 8'h55;
        bus8.b     = 8'h55;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        assertCount++;
        if ({bus8.busy, bus8.done, bus8.gt, bus8.eq, bus8.lt} !== 5'b00000) begin
            failCount++;
            $display("[TB] FAIL reset_mid_run: got %b expected 00000",
                     {bus8.busy, bus8.done, bus8.gt, bus8.eq, bus8.lt});
        end
        doCompare8(8'h00, 8'h00, 3'b010, 4, "eq_after_reset");
    endtask

    task automatic doCompare2(input logic [1:0] a, input logic [1:0] b,
                              input logic [2:0] expRes, input string name);
        bus2.a     = a;
        bus2.b     = b;
        bus2.start = 1'b1;
        tick();
        bus2.start = 1'b0;
        assertCount++;
        if ({bus2.busy, bus2.done} !== 2'b10) begin
            failCount++;
            $display("[TB] FAIL %s_run: got busy/done=%b expected 10", name, {bus2.busy, bus2.done});
        end
        tick();
        assertCount++;
        if ({bus2.busy, bus2.done, bus2.gt, bus2.eq, bus2.lt} !== {2'b11, expRes}) begin
            failCount++;
            $display("[TB] FAIL %s_done: got %b expected %b", name,
                     {bus2.busy, bus2.done, bus2.gt, bus2.eq, bus2.lt}, {2'b11, expRes});
        end
        tick();
        assertCount++;
        if ({bus2.busy, bus2.done} !== 2'b00) begin
            failCount++;
            $display("[TB] FAIL %s_idle: got busy/done=%b expected 00", name, {bus2.busy, bus2.done});
        end
    endtask

    task automatic test_width2();
        doCompare2(2'b11, 2'b10, 3'b100, "w2_gt");
        doCompare2(2'b01, 2'b10, 3'b001, "w2_lt");
        doCompare2(2'b10, 2'b10, 3'b010, "w2_eq");
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        test_reset();
        test_equal();
        test_gt_early();
        test_lt_last_pair();
        test_back_to_back();
        test_reset_mid_run();
        test_width2();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule

// File: doc/serial_compare_ctrl.md
Name: serial_compare_ctrl

Overview:
- Sequencer that compares two WIDTH-bit unsigned operands using a single shared 2-bit magnitude-compare slice.
- Iterates MSB-first, one 2-bit pair per clock, with a start/busy/done handshake.
- Sits between a requesting controller and the 2-bit comparator datapath; extends the 2-bit comparator to wide words without replicating the slice.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2; number of pairs N = WIDTH/2.

Ports:
- clk  input  1  single system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when in IDLE
- a  input  WIDTH  operand A, sampled on the accept edge
- b  input  WIDTH  operand B, sampled on the accept edge
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; result valid
- gt  output  1  A > B (registered)
- eq  output  1  A == B (registered)
- lt  output  1  A < B (registered)

Behaviour:
- Reset: rst sampled high at an edge forces the following outputs, from the next cycle:
  - state = IDLE
  - busy = 0, done = 0, gt = eq = lt = 0
  - shift registers and pair counter = 0
- Reset has priority over all other activity, including mid-RUN; the in-flight compare is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy = 0.
  - On start = 1 at an edge, the block accepts the request:
    - latch a and b into shift registers sa and sb
    - pair counter = 0, decided flag = 0
    - gt = eq = lt = 0
    - go to RUN
  - With start = 0, remain in IDLE; gt/eq/lt hold the previous result.
- RUN, each edge:
  - Compare the top pairs sa[W-1:W-2] and sb[W-1:W-2] as 2-bit unsigned values.
  - If not yet decided and the pairs differ:
    - set gt or lt accordingly
    - set the decided flag
  - Shift sa and sb left by 2 (zero fill) and increment the counter.
  - Once decided, later pairs never change the result.
  - Transition to DONE when the counter reaches N-1, i.e. on the edge that processes the last pair.
  - If no pair differed, set eq = 1 on that edge.
- DONE:
  - done = 1 for exactly one cycle, busy = 1; gt/eq/lt are valid.
  - Next edge goes to IDLE unconditionally.
- start is ignored in RUN and DONE; the operands of an ignored start are never captured.
- A new request can be accepted on the first IDLE cycle after DONE; minimum request spacing is N+2 cycles.
- Result outputs:
  - exactly one of gt/eq/lt is 1 whenever done = 1
  - all three hold their value after DONE until the next accept clears them
- Latency, with the accept edge at t0:
  - full scan: DONE entered at edge t0+N; done is high in the cycle following that edge
- WIDTH = 2 (N = 1): RUN lasts one edge, then DONE.

Optional Feature:
- Macro: SERIAL_COMPARE_EARLY_EXIT_EN.
- When defined:
  - RUN transitions to DONE on the first edge whose pair differs, or at the last pair if none differs.
  - Latency = j edges after the accept, where j is the 1-based index of the first differing pair, counted from the MSB.
  - The remaining pairs are not processed.
- When undefined:
  - Always N edges in RUN (constant latency, data-independent timing).
  - The result is identical in both builds.

Test Plan:
1. WIDTH=8, A=0xA5, B=0xA5, pulse start -> eq=1, gt=lt=0; done high after 4 RUN edges in both builds; busy=1 for 5 cycles.
2. WIDTH=8, A=0x80, B=0x7F:
   - -> gt=1.
   - With SERIAL_COMPARE_EARLY_EXIT_EN: done after 1 RUN edge.
   - Without: done after 4 RUN edges; result unchanged by the lower pairs (0x00 vs 0x3F... differs but ignored).
3. WIDTH=8, A=0x12, B=0x13 -> lt=1; done after 4 RUN edges in both builds (difference only in the last pair).
4. WIDTH=8, start held high for 10 cycles, A=0x40/B=0x30 on accept, then changed to A=0x00/B=0xFF:
   - -> first result gt=1.
   - Second accept occurs on the IDLE cycle after DONE and yields lt=1.
   - Mid-run operand changes are ignored.
5. WIDTH=8, rst asserted at the 2nd RUN edge of a compare -> next cycle busy=0, done=0, gt=eq=lt=0; a subsequent start with A=B=0x00 gives eq=1.
6. WIDTH=2, A=2'b11, B=2'b10 -> gt=1, done one cycle after the single RUN edge; A=2'b01, B=2'b10 -> lt=1.
